// File: rtl/aes_block_loader.sv
// Byte-stream loader that assembles a 16-byte AES key and a 16-byte plaintext block for aesMain.
// Define AES_KEY_REUSE_EN to let a block reuse the previously loaded key.
module aes_block_loader #(
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         key_reuse,
    output logic [127:0] blk_state,
    output logic [127:0] blk_key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         busy,
    output logic         err_timeout
);

    // state     | meaning
    // LOAD_KEY  | collecting key bytes into blk_key
    // LOAD_TEXT | collecting plaintext bytes into blk_state
    // PRESENT   | block complete, waiting for blk_ready
    typedef enum logic [1:0] {
        LOAD_KEY  = 2'd0,
        LOAD_TEXT = 2'd1,
        PRESENT   = 2'd2
    } state_e;

    localparam int SW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_RELOAD = (IDLE_TIMEOUT > 0) ? SW'(IDLE_TIMEOUT - 1) : '0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          key_loaded_q, key_loaded_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  text_q, text_d;
    logic [6:0]    byte_lo;
    logic          stalling;
    logic          flush;
    logic          reuse_ok;

    // Byte cnt lands at bits [127-8*cnt -: 8]; ~cnt equals 15-cnt.
    assign byte_lo   = {~cnt_q, 3'b000};
    assign busy      = (state_q == PRESENT) || (cnt_q != 4'd0);
    assign stalling  = (state_q != PRESENT) && (cnt_q != 4'd0);
    // Down-counter holds stall cycles left before the flush cycle itself.
    assign flush     = (IDLE_TIMEOUT > 0) && stalling && (stall_q == '0);
    assign blk_valid = (state_q == PRESENT);
    assign blk_key   = key_q;
    assign blk_state = text_q;

`ifdef AES_KEY_REUSE_EN
    assign reuse_ok = key_reuse && key_loaded_q;
`else
    logic unused_reuse;
    assign unused_reuse = key_reuse ^ key_loaded_q;
    assign reuse_ok     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        stall_d      = STALL_RELOAD;
        key_d        = key_q;
        text_d       = text_q;
        s_ready      = 1'b0;
        err_timeout  = 1'b0;
        case (state_q)
            LOAD_KEY, LOAD_TEXT: begin
                // The flush cycle refuses the byte so the handshake stays honest.
                s_ready = !flush;
                if (flush) begin
                    err_timeout  = 1'b1;
                    state_d      = LOAD_KEY;
                    cnt_d        = 4'd0;
                    key_loaded_d = 1'b0;
                end else if (s_valid) begin
                    cnt_d = cnt_q + 4'd1;
                    if (state_q == LOAD_KEY) begin
                        key_d[byte_lo +: 8] = s_data;
                    end else begin
                        text_d[byte_lo +: 8] = s_data;
                    end
                    if (cnt_q == 4'd15) begin
                        if (state_q == LOAD_KEY) begin
                            state_d      = LOAD_TEXT;
                            key_loaded_d = 1'b1;
                        end else begin
                            state_d = PRESENT;
                        end
                    end
                end else if (stalling) begin
                    stall_d = stall_q - SW'(1);
                end
            end
            PRESENT: begin
                if (blk_ready) begin
                    state_d = reuse_ok ? LOAD_TEXT : LOAD_KEY;
                end
            end
            default: begin
                state_d = LOAD_KEY;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD_KEY;
            cnt_q        <= 4'd0;
            key_loaded_q <= 1'b0;
            stall_q      <= STALL_RELOAD;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            stall_q      <= stall_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= '0;
            text_q <= '0;
        end else begin
            key_q  <= key_d;
            text_q <= text_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: two instances (no timeout / IDLE_TIMEOUT=4) share inputs and are
// each tracked by a byte-level reference model; directed vectors cover the corner cases.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         key_reuse;
    logic         blk_ready;

    logic         a_s_ready, a_blk_valid, a_busy, a_err;
    logic [127:0] a_key, a_state;
    logic         b_s_ready, b_blk_valid, b_busy, b_err;
    logic [127:0] b_key, b_state;

    always #5 clk = ~clk;

    aes_block_loader #(.IDLE_TIMEOUT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(a_s_ready),
        .key_reuse(key_reuse), .blk_state(a_state), .blk_key(a_key), .blk_valid(a_blk_valid),
        .blk_ready(blk_ready), .busy(a_busy), .err_timeout(a_err)
    );

    aes_block_loader #(.IDLE_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(b_s_ready),
        .key_reuse(key_reuse), .blk_state(b_state), .blk_key(b_key), .blk_valid(b_blk_valid),
        .blk_ready(blk_ready), .busy(b_busy), .err_timeout(b_err)
    );

`ifdef AES_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    // phase: 0 gathering key, 1 gathering text, 2 block on offer; n = bytes in this phase;
    // idle = consecutive cycles without progress while a partial block is held.
    typedef struct {
        int           phase;
        int           n;
        bit           kl;
        int           idle;
        logic [127:0] key;
        logic [127:0] txt;
    } mdl_t;

    typedef struct {
        logic [127:0] kin;
        logic [127:0] tin;
        logic [127:0] kexp;
        logic [127:0] texp;
    } vec_t;

    mdl_t ma, mb;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   a_err_seen;

    function automatic mdl_t mreset();
        mdl_t m;
        m.phase = 0; m.n = 0; m.kl = 1'b0; m.idle = 0; m.key = '0; m.txt = '0;
        return m;
    endfunction

    function automatic bit mflush(mdl_t m, int t);
        return (t > 0) && (m.phase != 2) && (m.n != 0) && (m.idle == t - 1);
    endfunction

    function automatic bit mready(mdl_t m, int t);
        return (m.phase != 2) && !mflush(m, t);
    endfunction

    function automatic mdl_t mstep(mdl_t m, int t, bit v, logic [7:0] d, bit br, bit kr);
        mdl_t r = m;
        if (m.phase == 2) begin
            if (br) begin
                r.phase = (REUSE && kr && m.kl) ? 1 : 0;
                r.idle  = 0;
            end
        end else if (mflush(m, t)) begin
            r.phase = 0; r.n = 0; r.kl = 1'b0; r.idle = 0;
        end else if (v) begin
            if (m.phase == 0) r.key[127 - 8*m.n -: 8] = d;
            else              r.txt[127 - 8*m.n -: 8] = d;
            r.n    = m.n + 1;
            r.idle = 0;
            if (r.n == 16) begin
                r.n = 0;
                if (m.phase == 0) begin
                    r.phase = 1;
                    r.kl    = 1'b1;
                end else begin
                    r.phase = 2;
                end
            end
        end else if (m.n != 0) begin
            r.idle = m.idle + 1;
        end else begin
            r.idle = 0;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [263:0] act, input logic [263:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        check("cyc_a", {a_s_ready, a_blk_valid, a_busy, a_err, a_key, a_state},
              {mready(ma, 0), ma.phase == 2, (ma.phase == 2) || (ma.n != 0), mflush(ma, 0), ma.key, ma.txt});
        check("cyc_b", {b_s_ready, b_blk_valid, b_busy, b_err, b_key, b_state},
              {mready(mb, 4), mb.phase == 2, (mb.phase == 2) || (mb.n != 0), mflush(mb, 4), mb.key, mb.txt});
        if (a_err) a_err_seen = 1'b1;
    endtask

    task automatic cycle();
        cmp_cycle();
        @(posedge clk);
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, 0, s_valid, s_data, blk_ready, key_reuse);
            mb = mstep(mb, 4, s_valid, s_data, blk_ready, key_reuse);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ma = mreset();
        mb = mreset();
        #1;
        check("rst_a", {a_s_ready, a_blk_valid, a_busy, a_err, a_key, a_state}, {4'b1000, 256'd0});
        check("rst_b", {b_s_ready, b_blk_valid, b_busy, b_err, b_key, b_state}, {4'b1000, 256'd0});
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input bit use_b, input logic [7:0] d);
        bit rdy;
        s_valid = 1'b1;
        s_data  = d;
        for (int k = 0; k < 50; k++) begin
            rdy = use_b ? mready(mb, 4) : mready(ma, 0);
            cycle();
            if (rdy) begin
                s_valid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: byte %h not accepted within 50 cycles", d);
        s_valid = 1'b0;
    endtask

    task automatic send_block(input bit use_b, input logic [127:0] k, input logic [127:0] t, input int maxgap);
        int gaps;
        for (int i = 0; i < 32; i++) begin
            gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                cycle();
            end
            if (i < 16) send_byte(use_b, k[127 - 8*i -: 8]);
            else        send_byte(use_b, t[127 - 8*(i-16) -: 8]);
        end
    endtask

    initial begin
        vec_t         vecs[3];
        logic [127:0] tw;

        vecs[0] = '{"Thats my Kung Fu", "Two One Nine Two",
                    128'h5468617473206D79204B756E67204675, 128'h54776F204F6E65204E696E652054776F};
        vecs[1] = '{"AAAAAAAAAAAAAAAA", "0123456789abcdef",
                    128'h41414141414141414141414141414141, 128'h30313233343536373839616263646566};
        vecs[2] = '{"Sixteen byte key", 128'hFF00EE11DD22CC33BB44AA5599668877,
                    128'h5369787465656E2062797465206B6579, 128'hFF00EE11DD22CC33BB44AA5599668877};
        tw = "Two One Nine Two";

        s_valid = 1'b0; s_data = 8'h00; key_reuse = 1'b0; blk_ready = 1'b1;
        rst_n = 1'b1;
        ma = mreset();
        mb = mreset();
        a_err_seen = 1'b0;
        #2;
        do_reset();

        // Table vectors: blk_valid one cycle after the 32nd byte, both buses correct.
        for (int v = 0; v < 3; v++) begin
            send_block(1'b1, vecs[v].kin, vecs[v].tin, 0);
            check("tbl_valid", {a_blk_valid, b_blk_valid}, 264'd3);
            check("tbl_key_a", a_key, vecs[v].kexp);
            check("tbl_state_a", a_state, vecs[v].texp);
            check("tbl_key_b", b_key, vecs[v].kexp);
            check("tbl_state_b", b_state, vecs[v].texp);
            cycle();
            check("tbl_leave", b_blk_valid, 264'd0);
        end

        // Backpressure: block held for 10 cycles, leaves on the cycle blk_ready rises.
        blk_ready = 1'b0;
        send_block(1'b1, vecs[0].kin, vecs[0].tin, 0);
        for (int c = 0; c < 10; c++) begin
            check("bp_hold", {b_blk_valid, b_s_ready, b_key, b_state}, {2'b10, vecs[0].kexp, vecs[0].texp});
            cycle();
        end
        blk_ready = 1'b1;
        check("bp_still_valid", b_blk_valid, 264'd1);
        cycle();
        check("bp_left", {b_blk_valid, b_s_ready}, 264'd1);

        // Random gaps with no timeout configured.
        do_reset();
        a_err_seen = 1'b0;
        send_block(1'b0, vecs[0].kin, vecs[0].tin, 6);
        check("gap_block", {a_blk_valid, a_key, a_state}, {1'b1, vecs[0].kexp, vecs[0].texp});
        cycle();
        check("gap_no_err", a_err_seen, 264'd0);

        // Timeout: 5 key bytes then a stall; flush on the 4th stall cycle refuses a byte.
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(1'b1, vecs[1].kin[127 - 8*i -: 8]);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin
                s_valid = 1'b1;
                s_data  = 8'hAA;
                check("to_refuse", b_s_ready, 264'd0);
            end
            check("to_err", b_err, (k == 4) ? 264'd1 : 264'd0);
            cycle();
        end
        s_valid = 1'b0;
        check("to_after", {b_busy, b_err}, 264'd0);
        send_block(1'b1, vecs[0].kin, vecs[0].tin, 0);
        check("to_block", {b_blk_valid, b_key, b_state}, {1'b1, vecs[0].kexp, vecs[0].texp});
        cycle();

        // Key reuse request at the handshake.
        do_reset();
        send_block(1'b1, vecs[0].kin, vecs[2].tin, 0);
        key_reuse = 1'b1;
        cycle();
        key_reuse = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(1'b1, tw[127 - 8*i -: 8]);
`ifdef AES_KEY_REUSE_EN
        check("reuse_block", {b_blk_valid, b_key, b_state}, {1'b1, vecs[0].kexp, vecs[0].texp});
`else
        check("reuse_off", {b_blk_valid, b_key, b_state}, {1'b0, vecs[0].texp, vecs[2].texp});
`endif
        cycle();

        // Reset mid-load and while presenting.
        do_reset();
        for (int i = 0; i < 20; i++)
            send_byte(1'b1, (i < 16) ? vecs[2].kin[127 - 8*i -: 8] : vecs[2].tin[127 - 8*(i-16) -: 8]);
        check("mid_busy", b_busy, 264'd1);
        do_reset();
        check("mid_rst", {b_blk_valid, b_busy, a_blk_valid, a_busy}, 264'd0);
        send_block(1'b1, vecs[1].kin, vecs[1].tin, 0);
        check("mid_block", {b_blk_valid, b_key, b_state}, {1'b1, vecs[1].kexp, vecs[1].texp});
        do_reset();
        check("present_rst", {b_blk_valid, b_busy, b_err}, 264'd0);

        // Randomized traffic against the models.
        for (int c = 0; c < 3000; c++) begin
            s_valid   = 1'($urandom_range(1, 0));
            s_data    = 8'($urandom);
            blk_ready = ($urandom_range(2, 0) != 0);
            key_reuse = 1'($urandom_range(1, 0));
            if ($urandom_range(399, 0) == 0) do_reset();
            else                             cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
